// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: sequential address generation, single-outstanding req/ack
// memory port, show-ahead instruction buffer and redirect flush.
module rv32i_fetch #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [ILEN-1:0] mem_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [ILEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  logic [1:0]      r_state;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_wptr;
  logic [ILEN-1:0] r_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_pcs   [FIFO_DEPTH];

  logic [1:0]      w_state_nxt;
  logic            w_req_nxt;
  logic [XLEN-1:0] w_addr_nxt;
  logic [XLEN-1:0] w_fetch_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_ack;
  logic            w_pop;
  logic            w_push;
  logic            w_credit;
  logic            w_issue;
  logic [XLEN-1:0] w_issue_pc;
  logic [XLEN-1:0] w_redir_pc;

  assign w_ack      = r_req & mem_ack_i;
  assign w_pop      = (r_count != '0) & ready_i & ~redirect_i;
  assign w_push     = w_ack & (r_state == S_REQ) & ~redirect_i;
  assign w_redir_pc = redirect_pc_i & ~XLEN'(3);

  // Occupancy after this cycle's push/pop; a new request needs one free slot beyond it.
  always_comb begin
    w_count_nxt = r_count;
    if (redirect_i) w_count_nxt = '0;
    else            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  assign w_credit = (w_count_nxt < CW'(FIFO_DEPTH));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, request control and fetch address sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_fetch_nxt = r_fetch_pc;
    w_issue     = 1'b0;
    w_issue_pc  = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect_i) begin
          w_issue    = 1'b1;
          w_issue_pc = w_redir_pc;
        end else if (w_credit) begin
          w_issue = 1'b1;
        end
      end
      S_REQ: begin
        if (redirect_i && w_ack) begin
          w_issue    = 1'b1;
          w_issue_pc = w_redir_pc;
        end else if (redirect_i) begin
          w_state_nxt = S_DRAIN;
          w_fetch_nxt = w_redir_pc;
        end else if (w_ack) begin
          if (w_credit) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_i && w_ack) begin
          w_issue    = 1'b1;
          w_issue_pc = w_redir_pc;
        end else if (redirect_i) begin
          w_fetch_nxt = w_redir_pc;
        end else if (w_ack) begin
          w_issue = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
    if (w_issue) begin
      w_state_nxt = S_REQ;
      w_req_nxt   = 1'b1;
      w_addr_nxt  = w_issue_pc;
      w_fetch_nxt = w_issue_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_pc <= w_fetch_nxt;
    end
  end

  // Instruction buffer; redirect realigns both pointers with the cleared count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pcs[i]   <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (redirect_i) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        if (w_push) begin
          r_instr[r_wptr] <= mem_data_i;
          r_pcs[r_wptr]   <= r_addr;
          r_wptr          <= r_wptr + PW'(1);
        end
      end
    end
  end

  assign mem_req_o     = r_req;
  assign mem_addr_o    = r_addr;
  assign valid_o       = (r_count != '0);
  assign instruction_o = valid_o ? r_instr[r_rptr] : NOP;
  assign pc_o          = valid_o ? r_pcs[r_rptr] : '0;

endmodule

// File: doc/rv32i_fetch.md
Name: rv32i_fetch

Overview:
Instruction fetch stage directly upstream of the rv32i decode stage. It generates sequential fetch addresses and issues single-outstanding requests on a req/ack instruction-memory port. Returned words are buffered in a small show-ahead FIFO. The FIFO head is presented to decode as instruction/PC/valid. A redirect from a later stage (jump, branch or trap target) flushes the buffer and any in-flight response, then restarts fetch at the new address.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
RESET_PC, 32'h00000000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  asynchronous active-low reset
mem_req_o  output  1  fetch request, held until acked
mem_addr_o  output  XLEN  fetch byte address, word aligned, stable while mem_req_o high
mem_ack_i  input  1  request accepted; mem_data_i valid this cycle
mem_data_i  input  ILEN  fetched instruction word
redirect_i  input  1  flush and restart fetch
redirect_pc_i  input  XLEN  restart address; bits [1:0] ignored (treated as 0)
ready_i  input  1  decode consumes head entry this cycle
valid_o  output  1  head entry valid (feeds decode data_ready_i)
instruction_o  output  ILEN  head instruction
pc_o  output  XLEN  byte address of head instruction

Behaviour:
- Reset (async assert, sync release) sets:
  - mem_req_o=0, mem_addr_o=RESET_PC, fetch_pc=RESET_PC
  - FIFO count=0, valid_o=0, state=IDLE
- First request is issued in the first cycle after reset release.
- All outputs are registered or derived from registers. No combinational path from mem_ack_i or ready_i to any output.
- Memory handshake:
  - A request is outstanding while mem_req_o=1.
  - mem_addr_o must not change while mem_req_o=1 and mem_ack_i=0.
  - The transfer completes in the cycle mem_ack_i=1 with mem_req_o=1.
  - mem_ack_i while mem_req_o=0 is ignored.
- Credit rule: a new request is issued only if (count + outstanding) < FIFO_DEPTH after this cycle's pop. The FIFO therefore never overflows and never drops a valid ack.
- Back-to-back: if the credit allows at an ack edge, mem_req_o stays 1 and mem_addr_o advances by 4 on the same edge. With zero-wait memory this gives 1 instruction/cycle.
- fetch_pc increments by 4 on each accepted request and wraps modulo 2^XLEN.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding; its data will be kept.
  - DRAIN: request outstanding; its data will be discarded.
- Transitions:
  - IDLE -> REQ when the credit allows.
  - REQ + ack -> REQ if the credit allows, else IDLE.
  - REQ + redirect (no ack this cycle) -> DRAIN.
  - DRAIN + ack -> REQ at fetch_pc (already the redirect target); data is not pushed.
  - Any state + redirect + ack in the same cycle: data dropped, next state REQ at redirect_pc_i.
  - IDLE + redirect -> REQ at redirect_pc_i.
- FIFO push: the ack word is pushed with its address in state REQ with no redirect this cycle.
- FIFO pop: valid_o & ready_i, ignored if redirect_i=1.
- Simultaneous push and pop: count is unchanged, order is preserved.
- Redirect:
  - Clears count to 0, so valid_o=0 the next cycle.
  - Loads fetch_pc from redirect_pc_i.
  - Takes priority over push, pop and sequential increment.
  - Repeated redirects in DRAIN update fetch_pc and remain in DRAIN.
- When valid_o=0: instruction_o=32'h00000013 (NOP) and pc_o=0, so decode sees a harmless word.
- Reset asserted mid-transaction abandons the outstanding request. The memory side must tolerate mem_req_o dropping without an ack.

Test Plan:
- Zero-wait memory (ack same cycle as req), ready_i=1: after reset, mem_addr_o sequence 0,4,8,C on consecutive cycles; valid_o first high 1 cycle after first ack with pc_o=0; one instruction per cycle thereafter.
- ready_i=0 held, memory always acks: exactly FIFO_DEPTH=2 acks accepted, then mem_req_o=0. Raising ready_i drains the entries in order (pc 0,4), then fetch resumes at 8.
- Memory acks after 3 wait cycles: mem_addr_o stays 0x0 for all 4 request cycles; instruction_o equals the acked word with pc_o=0.
- Redirect to 0x100 while a request to 0x8 awaits ack (2 more wait cycles): state DRAIN; the 0x8 data is never presented; next request address is 0x100; valid_o stays low until 0x100 returns; FIFO is empty immediately after redirect.
- Redirect to 0x203 in the same cycle as ack of 0xC with ready_i=1: 0xC dropped, the pop is ignored, next mem_addr_o=0x200, first valid pc_o=0x200.
- fetch_pc=0xFFFFFFFC sequential: next request address 0x00000000 (wrap). Reset asserted mid-request: mem_req_o=0, valid_o=0 immediately; fetch restarts at RESET_PC.
